mem_wb_stage: RTL and testbench

MEM/WB pipeline register of the RISC-V core. It captures memory-stage results and aligns and extends load data. It drives the four candidate operands and the 2-bit select into the writeback 4:1 mux, whose output feeds the register file write port. The stage also holds the stall/flush handling for that boundary and a retired-instruction counter.

---
 rtl/mem_wb_stage.sv | 166 ++++++++++++++++
 tb/tb_mem_wb_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: aligns and extends loads, qualifies the rd write, counts retirements.
// 1-cycle registered latency; stall holds every flop, flush kills the captured slot (flush wins over stall).
module mem_wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_mem_rdata,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic [XLEN-1:0] in_imm,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_addr_lo,
  input  logic [1:0]      in_wb_sel,
  input  logic            in_reg_write,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  output logic [XLEN-1:0] out_alu_result,
  output logic [XLEN-1:0] out_load_data,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic [XLEN-1:0] out_imm,
  output logic [1:0]      out_wb_sel,
  output logic            out_reg_write,
  output logic [4:0]      out_rd,
  output logic            out_misaligned,
  output logic [31:0]     out_retired
);

  localparam logic [1:0] WB_LOAD = 2'b01;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] load_ext;
  logic            load_misaligned;
  logic            reg_write_qual;

  logic            valid_q,      valid_d;
  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] load_data_q,  load_data_d;
  logic [XLEN-1:0] pc_plus4_q,   pc_plus4_d;
  logic [XLEN-1:0] imm_q,        imm_d;
  logic [1:0]      wb_sel_q,     wb_sel_d;
  logic            reg_write_q,  reg_write_d;
  logic [4:0]      rd_q,         rd_d;
  logic            misaligned_q, misaligned_d;
  logic [31:0]     retired_q,    retired_d;

  // Little-endian lane pick ahead of the register.
  always_comb begin
    load_byte = 8'h00;
    case (in_addr_lo)
      2'b00:   load_byte = in_mem_rdata[7:0];
      2'b01:   load_byte = in_mem_rdata[15:8];
      2'b10:   load_byte = in_mem_rdata[23:16];
      default: load_byte = in_mem_rdata[31:24];
    endcase
    load_half = in_addr_lo[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
  end

  always_comb begin
    load_misaligned = 1'b0;
    if (in_wb_sel == WB_LOAD) begin
      case (in_funct3)
        F3_LH, F3_LHU: load_misaligned = in_addr_lo[0];
        F3_LW:         load_misaligned = (in_addr_lo != 2'b00);
        default:       load_misaligned = 1'b0;
      endcase
    end
  end

  always_comb begin
    load_ext = in_mem_rdata;
    case (in_funct3)
      F3_LB:   load_ext = {{(XLEN-8){load_byte[7]}}, load_byte};
      F3_LBU:  load_ext = {{(XLEN-8){1'b0}}, load_byte};
      F3_LH:   load_ext = {{(XLEN-16){load_half[15]}}, load_half};
      F3_LHU:  load_ext = {{(XLEN-16){1'b0}}, load_half};
      default: load_ext = in_mem_rdata;
    endcase
    if (load_misaligned) begin
      load_ext = '0;
    end
  end

  assign reg_write_qual = in_reg_write & in_valid & (in_rd != 5'd0) & ~load_misaligned;

  always_comb begin
    valid_d      = valid_q;
    alu_result_d = alu_result_q;
    load_data_d  = load_data_q;
    pc_plus4_d   = pc_plus4_q;
    imm_d        = imm_q;
    wb_sel_d     = wb_sel_q;
    reg_write_d  = reg_write_q;
    rd_d         = rd_q;
    misaligned_d = misaligned_q;
    retired_d    = retired_q;
    if (flush || !stall) begin
      alu_result_d = in_alu_result;
      load_data_d  = load_ext;
      pc_plus4_d   = in_pc_plus4;
      imm_d        = in_imm;
      wb_sel_d     = in_wb_sel;
    end
    if (flush) begin
      // Squashed slot: control cleared, data left as don't-care.
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      rd_d         = 5'd0;
      misaligned_d = 1'b0;
    end else if (!stall) begin
      valid_d      = in_valid;
      reg_write_d  = reg_write_qual;
      rd_d         = in_rd;
      misaligned_d = load_misaligned;
      retired_d    = retired_q + {31'd0, in_valid};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      alu_result_q <= '0;
      load_data_q  <= '0;
      pc_plus4_q   <= '0;
      imm_q        <= '0;
      wb_sel_q     <= 2'b00;
      reg_write_q  <= 1'b0;
      rd_q         <= 5'd0;
      misaligned_q <= 1'b0;
      retired_q    <= 32'd0;
    end else begin
      valid_q      <= valid_d;
      alu_result_q <= alu_result_d;
      load_data_q  <= load_data_d;
      pc_plus4_q   <= pc_plus4_d;
      imm_q        <= imm_d;
      wb_sel_q     <= wb_sel_d;
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      misaligned_q <= misaligned_d;
      retired_q    <= retired_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_alu_result = alu_result_q;
  assign out_load_data  = load_data_q;
  assign out_pc_plus4   = pc_plus4_q;
  assign out_imm        = imm_q;
  assign out_wb_sel     = wb_sel_q;
  assign out_reg_write  = reg_write_q;
  assign out_rd         = rd_q;
  assign out_misaligned = misaligned_q;
  assign out_retired    = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: load extraction, x0/misalign write gating, stall/flush, reset, counter wrap.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, in_valid;
  logic [31:0] in_alu_result, in_mem_rdata, in_pc_plus4, in_imm;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo, in_wb_sel;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic [31:0] out_alu_result, out_load_data, out_pc_plus4, out_imm;
  logic [1:0]  out_wb_sel;
  logic        out_reg_write;
  logic [4:0]  out_rd;
  logic        out_misaligned;
  logic [31:0] out_retired;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [31:0] exp_ret;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .in_pc_plus4(in_pc_plus4), .in_imm(in_imm), .in_funct3(in_funct3),
    .in_addr_lo(in_addr_lo), .in_wb_sel(in_wb_sel), .in_reg_write(in_reg_write),
    .in_rd(in_rd), .out_valid(out_valid), .out_alu_result(out_alu_result),
    .out_load_data(out_load_data), .out_pc_plus4(out_pc_plus4), .out_imm(out_imm),
    .out_wb_sel(out_wb_sel), .out_reg_write(out_reg_write), .out_rd(out_rd),
    .out_misaligned(out_misaligned), .out_retired(out_retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present inputs, then sample 1ns after the capturing edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [2:0] f3, input logic [1:0] lo,
                           input logic [1:0] sel, input logic rw, input logic [4:0] rd);
    in_valid     = v;
    in_funct3    = f3;
    in_addr_lo   = lo;
    in_wb_sel    = sel;
    in_reg_write = rw;
    in_rd        = rd;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    in_alu_result = 32'h0; in_mem_rdata = 32'h0; in_pc_plus4 = 32'h0; in_imm = 32'h0;
    set_instr(1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 5'd0);
    #2;
    chk("reset_valid",   {31'd0, out_valid}, 32'd0);
    chk("reset_retired", out_retired, 32'd0);
    chk("reset_load",    out_load_data, 32'd0);
    chk("reset_rw",      {31'd0, out_reg_write}, 32'd0);
    step();
    rst = 1'b0;
    exp_ret = 32'd0;

    // LB of lane 3 (0x80) sign-extends
    in_mem_rdata = 32'h80FF7F01; in_alu_result = 32'h0000_1003;
    set_instr(1'b1, 3'b000, 2'b11, 2'b01, 1'b1, 5'd5);
    step(); exp_ret++;
    chk("lb_data",    out_load_data, 32'hFFFFFF80);
    chk("lb_rw",      {31'd0, out_reg_write}, 32'd1);
    chk("lb_rd",      {27'd0, out_rd}, 32'd5);
    chk("lb_retired", out_retired, 32'd1);
    chk("lb_valid",   {31'd0, out_valid}, 32'd1);

    set_instr(1'b1, 3'b101, 2'b10, 2'b01, 1'b1, 5'd6);
    step(); exp_ret++;
    chk("lhu_data", out_load_data, 32'h000080FF);
    chk("lhu_mis",  {31'd0, out_misaligned}, 32'd0);

    set_instr(1'b1, 3'b010, 2'b01, 2'b01, 1'b1, 5'd7);
    step(); exp_ret++;
    chk("lw_mis_flag", {31'd0, out_misaligned}, 32'd1);
    chk("lw_mis_data", out_load_data, 32'h0);
    chk("lw_mis_rw",   {31'd0, out_reg_write}, 32'd0);
    chk("lw_mis_ret",  out_retired, exp_ret);

    set_instr(1'b1, 3'b100, 2'b01, 2'b01, 1'b1, 5'd8);
    step(); exp_ret++;
    chk("lbu_data", out_load_data, 32'h0000007F);
    chk("lbu_mis",  {31'd0, out_misaligned}, 32'd0);

    set_instr(1'b1, 3'b001, 2'b10, 2'b01, 1'b1, 5'd9);
    step(); exp_ret++;
    chk("lh_data", out_load_data, 32'hFFFF80FF);

    set_instr(1'b1, 3'b001, 2'b11, 2'b01, 1'b1, 5'd9);
    step(); exp_ret++;
    chk("lh_mis_flag", {31'd0, out_misaligned}, 32'd1);
    chk("lh_mis_data", out_load_data, 32'h0);

    set_instr(1'b1, 3'b010, 2'b00, 2'b01, 1'b1, 5'd10);
    step(); exp_ret++;
    chk("lw_data", out_load_data, 32'h80FF7F01);
    chk("lw_rw",   {31'd0, out_reg_write}, 32'd1);

    // x0 write suppressed; misalign ignored when not a load select
    in_pc_plus4 = 32'h00000104;
    set_instr(1'b1, 3'b010, 2'b01, 2'b10, 1'b1, 5'd0);
    step(); exp_ret++;
    chk("x0_rw",   {31'd0, out_reg_write}, 32'd0);
    chk("x0_sel",  {30'd0, out_wb_sel}, 32'd2);
    chk("x0_pc4",  out_pc_plus4, 32'h00000104);
    chk("x0_mis",  {31'd0, out_misaligned}, 32'd0);

    in_imm = 32'hABCDE000;
    set_instr(1'b1, 3'b000, 2'b00, 2'b11, 1'b1, 5'd4);
    step(); exp_ret++;
    chk("lui_imm", out_imm, 32'hABCDE000);
    chk("lui_sel", {30'd0, out_wb_sel}, 32'd3);

    in_alu_result = 32'h12345678;
    set_instr(1'b1, 3'b000, 2'b00, 2'b00, 1'b1, 5'd3);
    step(); exp_ret++;
    chk("alu_data", out_alu_result, 32'h12345678);
    chk("alu_rd",   {27'd0, out_rd}, 32'd3);
    chk("alu_ret",  out_retired, 32'd10);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_alu_result = 32'hDEAD0000 + i;
      set_instr(1'b1, 3'b000, 2'b00, 2'b01, 1'b1, 5'd7 + 5'(i));
      step();
      chk("stall_alu", out_alu_result, 32'h12345678);
      chk("stall_rd",  {27'd0, out_rd}, 32'd3);
      chk("stall_sel", {30'd0, out_wb_sel}, 32'd0);
      chk("stall_ret", out_retired, exp_ret);
    end

    flush = 1'b1;
    step();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_rw",    {31'd0, out_reg_write}, 32'd0);
    chk("flush_rd",    {27'd0, out_rd}, 32'd0);
    chk("flush_ret",   out_retired, exp_ret);
    flush = 1'b0; stall = 1'b0;

    // Bubble: write enable gated by in_valid, no retirement
    set_instr(1'b0, 3'b000, 2'b00, 2'b00, 1'b1, 5'd4);
    step();
    chk("bubble_rw",  {31'd0, out_reg_write}, 32'd0);
    chk("bubble_ret", out_retired, exp_ret);

    // Asynchronous reset between edges, then first edge captures normally
    set_instr(1'b1, 3'b000, 2'b00, 2'b00, 1'b1, 5'd4);
    step();
    chk("pre_rst_ret", out_retired, exp_ret + 32'd1);
    stall = 1'b1;
    rst = 1'b1;
    #1;
    chk("arst_ret",   out_retired, 32'd0);
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_alu",   out_alu_result, 32'd0);
    chk("arst_rd",    {27'd0, out_rd}, 32'd0);
    rst = 1'b0; stall = 1'b0;
    in_alu_result = 32'h00000055;
    set_instr(1'b1, 3'b000, 2'b00, 2'b00, 1'b1, 5'd12);
    step();
    chk("post_rst_ret", out_retired, 32'd1);
    chk("post_rst_alu", out_alu_result, 32'h00000055);

    // Counter wrap from a preloaded maximum
    dut.retired_q = 32'hFFFFFFFF;
    #1;
    chk("preload_ret", out_retired, 32'hFFFFFFFF);
    step();
    chk("wrap_ret", out_retired, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
